// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo constants: reserved tag, default widths and the name of the
// stats build macro (TOMASULO_CDB_STATS_EN).
package tomasulo_pkg;

    localparam int unsigned TAG_NONE           = 0;
    localparam int unsigned DEFAULT_TAG_WIDTH  = 4;
    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam string       STATS_MACRO_NAME   = "TOMASULO_CDB_STATS_EN";

endpackage

// File: rtl/tomasulo_rr_pick.sv
// Round-robin picker: first set bit of eligible searching upward from ptr,
// wrapping modulo N_REQ (non-power-of-two N_REQ supported).
module tomasulo_rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] eligible_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic             valid_o
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            // ptr < N_REQ and k < N_REQ, so one subtraction is enough to wrap.
            sum = {1'b0, ptr_i} + (PTR_W + 1)'(k);
            if (sum >= (PTR_W + 1)'(N_REQ)) begin
                sum = sum - (PTR_W + 1)'(N_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (!valid_o && eligible_i[idx]) begin
                grant_o[idx] = 1'b1;
                valid_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tomasulo_cdb_arbiter.sv
// Round-robin CDB arbiter with registered broadcast and one-hot RS clear.
// Optional 32-bit saturating stats counters under TOMASULO_CDB_STATS_EN.
module tomasulo_cdb_arbiter
    import tomasulo_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned TAG_WIDTH  = DEFAULT_TAG_WIDTH,
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*TAG_WIDTH-1:0]  req_tag,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        cdb_valid,
    output logic [TAG_WIDTH-1:0]        cdb_tag,
    output logic [DATA_WIDTH-1:0]       cdb_data,
    output logic [N_REQ-1:0]            rs_clear,
`ifdef TOMASULO_CDB_STATS_EN
    output logic [31:0]                 stat_bcast_cnt,
    output logic [31:0]                 stat_conflict_cnt,
`endif
    output logic                        err_tag_none
);

    localparam int unsigned PW = $clog2(N_REQ);

    logic [N_REQ-1:0]      tag_zero;
    logic [N_REQ-1:0]      eligible;
    logic [N_REQ-1:0]      grant;
    logic                  transfer;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [TAG_WIDTH-1:0]  sel_tag;
    logic [DATA_WIDTH-1:0] sel_data;

    logic                  cdb_valid_q;
    logic [TAG_WIDTH-1:0]  cdb_tag_q;
    logic [DATA_WIDTH-1:0] cdb_data_q;
    logic [N_REQ-1:0]      rs_clear_q;
    logic                  err_q;

    always_comb begin
        tag_zero = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            tag_zero[i] = (req_tag[i*TAG_WIDTH +: TAG_WIDTH] == TAG_WIDTH'(TAG_NONE));
        end
    end

    // Gating by rst keeps req_ready low while the state is being cleared.
    assign eligible = req_valid & ~tag_zero & {N_REQ{~flush & ~rst}};

    tomasulo_rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PW)
    ) u_pick (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .grant_o    (grant),
        .valid_o    (transfer)
    );

    assign req_ready = grant;

    always_comb begin
        sel_tag  = '0;
        sel_data = '0;
        ptr_d    = ptr_q;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_tag  = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
                sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                ptr_d    = (i == N_REQ - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            rs_clear_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            cdb_valid_q <= transfer;
            cdb_tag_q   <= sel_tag;
            cdb_data_q  <= sel_data;
            rs_clear_q  <= grant;
            err_q       <= err_q | (|(req_valid & tag_zero));
        end
    end

    assign cdb_valid    = cdb_valid_q;
    assign cdb_tag      = cdb_tag_q;
    assign cdb_data     = cdb_data_q;
    assign rs_clear     = rs_clear_q;
    assign err_tag_none = err_q;

`ifdef TOMASULO_CDB_STATS_EN
    logic [31:0] bcast_q, conflict_q;
    logic        conflict;

    // Two or more bits set iff clearing the lowest set bit leaves something.
    assign conflict = |(eligible & (eligible - N_REQ'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            bcast_q    <= '0;
            conflict_q <= '0;
        end else begin
            if (transfer && (bcast_q != '1)) begin
                bcast_q <= bcast_q + 32'd1;
            end
            if (conflict && (conflict_q != '1)) begin
                conflict_q <= conflict_q + 32'd1;
            end
        end
    end

    assign stat_bcast_cnt    = bcast_q;
    assign stat_conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_tomasulo_cdb_arbiter.sv
// Directed scoreboard bench for tomasulo_cdb_arbiter (4 ports, 4-bit tags, 32-bit data).
module tb_tomasulo_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [3:0]  v;
    logic [3:0]  tg [4];
    logic [31:0] dt [4];
    logic [15:0] req_tag;
    logic [127:0] req_data;
    logic [3:0]  req_ready;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic [3:0]  rs_clear;
    logic        err_tag_none;
`ifdef TOMASULO_CDB_STATS_EN
    logic [31:0] stat_bcast_cnt;
    logic [31:0] stat_conflict_cnt;
`endif

    typedef struct packed {
        logic        valid;
        logic [3:0]  tag;
        logic [31:0] data;
        logic [3:0]  clr;
    } bcast_t;

    bcast_t exp_q[$];
    int     n_pass  = 0;
    int     n_total = 0;
    int     mp      = 0;
    logic   err_m   = 1'b0;

    always #5 clk = ~clk;

    assign req_tag  = {tg[3], tg[2], tg[1], tg[0]};
    assign req_data = {dt[3], dt[2], dt[1], dt[0]};

    tomasulo_cdb_arbiter dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .req_valid         (v),
        .req_tag           (req_tag),
        .req_data          (req_data),
        .req_ready         (req_ready),
        .cdb_valid         (cdb_valid),
        .cdb_tag           (cdb_tag),
        .cdb_data          (cdb_data),
        .rs_clear          (rs_clear),
`ifdef TOMASULO_CDB_STATS_EN
        .stat_bcast_cnt    (stat_bcast_cnt),
        .stat_conflict_cnt (stat_conflict_cnt),
`endif
        .err_tag_none      (err_tag_none)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    endtask

    // Reference round-robin choice from the driven inputs and the bench's pointer.
    function automatic logic [3:0] model_grant(input logic [3:0] vv, input logic blk, input int p);
        logic [3:0] g;
        int idx;
        g = '0;
        for (int k = 0; k < 4; k++) begin
            idx = (p + k) % 4;
            if (g == 4'b0 && vv[idx] && tg[idx] != 4'd0 && !blk) g[idx] = 1'b1;
        end
        return g;
    endfunction

    // Called just after a negedge with inputs already driven; returns at the next negedge.
    task automatic step(input string name);
        logic [3:0] g;
        bcast_t     e;
        bcast_t     got;
        int         gi;
        #1;
        g  = model_grant(v, flush | rst, mp);
        gi = 0;
        for (int i = 0; i < 4; i++) if (g[i]) gi = i;
        chk({name, ".req_ready"}, 64'(req_ready), 64'(g));
        e = '0;
        if (!rst && g != 4'b0) e = '{valid: 1'b1, tag: tg[gi], data: dt[gi], clr: g};
        exp_q.push_back(e);
        @(posedge clk);
        if (rst) begin
            mp    = 0;
            err_m = 1'b0;
        end else begin
            if (g != 4'b0) mp = (gi + 1) % 4;
            for (int i = 0; i < 4; i++) if (v[i] && tg[i] == 4'd0) err_m = 1'b1;
        end
        #1;
        if (exp_q.size() == 0) begin
            chk({name, ".scoreboard_empty"}, 64'd1, 64'd0);
        end else begin
            got = '{valid: cdb_valid, tag: cdb_tag, data: cdb_data, clr: rs_clear};
            e   = exp_q.pop_front();
            chk({name, ".cdb_valid"}, 64'(got.valid), 64'(e.valid));
            chk({name, ".cdb_tag"},   64'(got.tag),   64'(e.tag));
            chk({name, ".cdb_data"},  64'(got.data),  64'(e.data));
            chk({name, ".rs_clear"},  64'(got.clr),   64'(e.clr));
        end
        chk({name, ".err_tag_none"}, 64'(err_tag_none), 64'(err_m));
        @(negedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        v     = 4'hF;
        for (int i = 0; i < 4; i++) begin
            tg[i] = 4'(i + 1);
            dt[i] = 32'hA0 + 32'(i);
        end
        @(negedge clk);
        step("reset");
        rst = 1'b0;

        // Held four-port stream: tags 1,2,3,4,1,... back to back.
        step("stream0");
        chk("first_grant_tag", 64'(cdb_tag), 64'd1);
        for (int c = 1; c < 10; c++) step($sformatf("stream%0d", c));
`ifdef TOMASULO_CDB_STATS_EN
        chk("stat_bcast_cnt",    64'(stat_bcast_cnt),    64'd10);
        chk("stat_conflict_cnt", 64'(stat_conflict_cnt), 64'd10);
`endif

        // Lone requester on port 2 (pointer sits at 2 after ten transfers).
        v = 4'b0100; tg[2] = 4'd5; dt[2] = 32'hDEAD_BEEF;
        step("single");
        chk("single_data_direct", 64'(cdb_data), 64'hDEAD_BEEF);
        v = 4'b0000;
        step("idle");

        // Tag 0 on port 1 is never granted and latches the error.
        v = 4'b1010; tg[1] = 4'd0; tg[3] = 4'd7;
        step("tag0");
        v = 4'b0000;
        step("after_tag0");
        step("err_sticky");

        // Flush blocks grants; pointer stays at 0 so port 0 wins afterwards.
        v = 4'b0011; tg[0] = 4'd1; tg[1] = 4'd2; flush = 1'b1;
        step("flush");
        flush = 1'b0;
        step("post_flush");
        v = 4'b0010;
        step("port1");
        v = 4'b0000;
        step("drain");

        // Mid-stream reset voids the visible grant and clears the sticky error.
        v = 4'hF; tg[1] = 4'd2; tg[2] = 4'd3; tg[3] = 4'd4;
        step("mid0");
        rst = 1'b1;
        step("mid_rst");
        rst = 1'b0;
        step("after_rst");
        v = 4'b0000;
        step("final_idle");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
